// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default width for the countdown timer.
`default_nettype none

package timer_pkg;

    localparam int          TIMER_WIDTH = 4;

    localparam logic [1:0]  ST_IDLE     = 2'b00;
    localparam logic [1:0]  ST_RUN      = 2'b01;
    localparam logic [1:0]  ST_DONE     = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage : timer_pkg

`default_nettype wire

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: client-side handshake bundle of the countdown timer.
`default_nettype none

interface countdown_timer_if #(
    parameter int WIDTH = timer_pkg::TIMER_WIDTH
);

    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             ack;
    logic [WIDTH-1:0] count_out;
    logic             busy;
    logic             done;

    modport master (
        output enable, load, load_value, ack,
        input  count_out, busy, done
    );

    modport slave (
        input  enable, load, load_value, ack,
        output count_out, busy, done
    );

endinterface : countdown_timer_if

`default_nettype wire

// File: rtl/down_counter_core.sv
// down_counter_core: loadable WIDTH-bit down-counter with terminal (count==1) detect.
`default_nettype none

module down_counter_core #(
    parameter int WIDTH = timer_pkg::TIMER_WIDTH
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] value_i,
    input  wire logic             dec_i,
    output logic      [WIDTH-1:0] count_o,
    output logic                  is_one_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority over decrement.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (dec_i) begin
            count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign is_one_o = (count_q == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule : down_counter_core

`default_nettype wire

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with done/ack handshake.
// Optional macro COUNTDOWN_AUTORELOAD_EN: periodic reload with a 1-cycle done pulse.
`default_nettype none

module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  wire logic        clock,
    input  wire logic        reset,
    countdown_timer_if.slave bus
);

    state_e           state_q;
    logic             busy_q;
    logic             done_q;

    logic             core_load;
    logic             core_dec;
    logic [WIDTH-1:0] core_value;
    logic [WIDTH-1:0] count;
    logic             is_one;
    logic             reload_hit;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            reload_q <= '0;
        end else if (bus.load) begin
            reload_q <= bus.load_value;
        end
    end

    // A zero reload value falls back to the plain DONE/ack handshake.
    assign reload_hit = is_one && (reload_q != '0);
`else
    assign reload_hit = 1'b0;
`endif

    always_comb begin
        core_load  = 1'b0;
        core_dec   = 1'b0;
        core_value = bus.load_value;
        if (bus.load) begin
            core_load = 1'b1;
        end else if ((state_q == RUN) && bus.enable) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
            if (reload_hit) begin
                core_load  = 1'b1;
                core_value = reload_q;
            end else begin
                core_dec = 1'b1;
            end
`else
            core_dec = 1'b1;
`endif
        end
    end

    down_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .load_i   (core_load),
        .value_i  (core_value),
        .dec_i    (core_dec),
        .count_o  (count),
        .is_one_o (is_one)
    );

    // Load wins in every state; a zero load goes straight to DONE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.load) begin
            if (bus.load_value == '0) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                RUN: begin
                    if (bus.enable && is_one) begin
                        if (reload_hit) begin
                            busy_q <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        done_q <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count_out = count;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule : countdown_timer

`default_nettype wire
